// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Package     : laser_pkg
// Description : Shared types and constants for the laser distance path.
//               Echo-emulator FSM states, the default distance width that is
//               shared with the measurement block, and the fill bit used to
//               build the out-of-range distance code (all ones).
// Revision    : 1.0  initial release
// ============================================================================
package laser_pkg;

    // Distance word width shared with the measurement block.
    localparam int DIST_W = 12;

    // The out-of-range distance code is this bit replicated across the word.
    localparam logic OOR_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ECHO  = 2'd2
    } echo_state_t;

endpackage : laser_pkg
`default_nettype wire

// File: rtl/laser_echo_emulator_rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : One-cycle rising-edge pulse for a signal that is already
//               synchronous to clk.
// Ports       : clk   in  clock, rising edge
//               reset in  asynchronous active-low reset
//               d     in  level input (same clock domain)
//               rise  out d & ~d_q, high for one cycle per 0->1 transition
// Revision    : 1.0  initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/laser_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module      : laser_echo_emulator
// Description : Target/reflection responder. On a rising edge of the laser
//               pulse L it waits 2*dist_set+1 cycles and then returns a
//               PULSE_W-cycle sensor pulse S, so the measurement path can be
//               exercised without optics.
// Ports       : clk       in   clock, rising edge
//               reset     in   asynchronous active-low reset
//               en        in   1 = respond; 0 = no echoes, abort in-flight echo
//               L         in   laser pulse (clk domain)
//               dist_set  in   target distance, all ones = out of range
//               S         out  reflected pulse (registered)
//               busy      out  high while an echo is in flight
//               miss      out  one-cycle pulse for an ignored L rise
//               echo_cnt  out  number of echoes issued (wraps)
// Revision    : 1.0  initial release
// ============================================================================
module laser_echo_emulator
    import laser_pkg::*;
#(
    parameter int DW      = DIST_W,
    parameter int PULSE_W = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             L,
    input  logic [DW-1:0]    dist_set,
    output logic             S,
    output logic             busy,
    output logic             miss,
    output logic [CNT_W-1:0] echo_cnt
);

    localparam int              PW_W         = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [PW_W-1:0] PW_LOAD      = PW_W'(PULSE_W - 1);
    localparam logic [DW-1:0]   OUT_OF_RANGE = {DW{OOR_FILL}};

    echo_state_t      state;
    logic [DW:0]      cnt;      // round-trip countdown, holds 2*D without overflow
    logic [PW_W-1:0]  pw;       // remaining S-high cycles minus one
    logic             rise;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .d     (L),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pw       <= '0;
            S        <= 1'b0;
            busy     <= 1'b0;
            miss     <= 1'b0;
            echo_cnt <= '0;
        end else begin
            miss <= 1'b0;
            if (!en) begin
                // Disabled: drop any echo in flight; rises are silently ignored.
                state <= IDLE;
                S     <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            if (dist_set == OUT_OF_RANGE) begin
                                miss <= 1'b1;
                            end else begin
                                // dist_set is captured only here.
                                cnt   <= {dist_set, 1'b0};
                                state <= DELAY;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    DELAY: begin
                        miss <= rise;
                        if (cnt == '0) begin
                            state    <= ECHO;
                            S        <= 1'b1;
                            echo_cnt <= echo_cnt + CNT_W'(1);
                            pw       <= PW_LOAD;
                        end else begin
                            cnt <= cnt - (DW + 1)'(1);
                        end
                    end
                    ECHO: begin
                        // A rise on the ECHO->IDLE edge still counts as busy.
                        miss <= rise;
                        if (pw == '0) begin
                            S     <= 1'b0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            pw <= pw - PW_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        S     <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : laser_echo_emulator
`default_nettype wire

// File: tb/tb_laser_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_laser_echo_emulator
// Description : Self-checking bench for laser_echo_emulator. A reference
//               model tracks each accepted echo as time windows (edge
//               numbers) and compares against the DUT after every edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_laser_echo_emulator;

    localparam int DW    = 12;
    localparam int PW    = 2;
    localparam int CNT_W = 8;
    localparam logic [DW-1:0] OOR = 12'hFFF;

    logic             clk;
    logic             reset;
    logic             en;
    logic             L;
    logic [DW-1:0]    dist_set;
    logic             S;
    logic             busy;
    logic             miss;
    logic [CNT_W-1:0] echo_cnt;

    laser_echo_emulator #(
        .DW      (DW),
        .PULSE_W (PW),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .L        (L),
        .dist_set (dist_set),
        .S        (S),
        .busy     (busy),
        .miss     (miss),
        .echo_cnt (echo_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int total  = 0;

    // ---------------- reference model ----------------
    int               n = 0;          // edge number
    logic             m_lprev;
    int               m_s_lo, m_s_hi, m_busy_end;
    logic [CNT_W-1:0] m_cnt;
    logic             m_s, m_busy, m_miss;

    task automatic model_reset();
        m_lprev    = 1'b0;
        m_s_lo     = -1;
        m_s_hi     = -2;
        m_busy_end = -1;
        m_cnt      = '0;
        m_s        = 1'b0;
        m_busy     = 1'b0;
        m_miss     = 1'b0;
    endtask

    // Echo accepted at edge k: S high after edges k+2D+1 .. k+2D+PW, busy
    // until the edge after that; any rise up to and including that edge misses.
    task automatic model_edge();
        logic rise;
        rise    = L & ~m_lprev;
        m_lprev = L;
        m_miss  = 1'b0;
        if (!en) begin
            m_s_lo     = -1;
            m_s_hi     = -2;
            m_busy_end = -1;
        end else begin
            if (n == m_s_lo) m_cnt = m_cnt + 1'b1;
            if (rise) begin
                if (n <= m_busy_end || dist_set == OOR) begin
                    m_miss = 1'b1;
                end else begin
                    m_s_lo     = n + 2 * int'(dist_set) + 1;
                    m_s_hi     = m_s_lo + PW - 1;
                    m_busy_end = m_s_hi + 1;
                end
            end
        end
        m_s    = (n >= m_s_lo) && (n <= m_s_hi);
        m_busy = (n < m_busy_end);
    endtask

    // Advance one edge, update the model, land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        n = n + 1;
        if (!reset) model_reset();
        else        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; en = 1'b1; L = 1'b0; dist_set = 12'd5;
        #2;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            L = ~L;
            step();
            total++;
            if (S !== 1'b0 || busy !== 1'b0 || miss !== 1'b0 || echo_cnt !== '0) begin
                $display("FAIL reset i=%0d S=%b busy=%b miss=%b cnt=%0d, want all 0", i, S, busy, miss, echo_cnt);
            end else passed++;
        end
        L = 1'b0;
        reset = 1'b1;
        model_reset();
        step();
    endtask

    // Fire one L pulse with distance d and report first S-high offset and width.
    task automatic fire_and_watch(input string name, input logic [DW-1:0] d, input int cycles,
                                  output int first, output int width);
        int k;
        dist_set = d; L = 1'b1;
        step();
        k = n; first = -1; width = 0;
        L = 1'b0;
        total++;
        if (S !== m_s || busy !== m_busy || miss !== m_miss || echo_cnt !== m_cnt) begin
            $display("FAIL %s edge0 S/busy/miss/cnt=%b%b%b/%0d want %b%b%b/%0d", name, S, busy, miss, echo_cnt, m_s, m_busy, m_miss, m_cnt);
        end else passed++;
        for (int i = 0; i < cycles; i++) begin
            dist_set = DW'($urandom_range(0, 4094));   // must be ignored
            step();
            if (S && first < 0) first = n - k;
            if (S) width++;
            total++;
            if (S !== m_s || busy !== m_busy || miss !== m_miss || echo_cnt !== m_cnt) begin
                $display("FAIL %s n=%0d S/busy/miss/cnt=%b%b%b/%0d want %b%b%b/%0d", name, n, S, busy, miss, echo_cnt, m_s, m_busy, m_miss, m_cnt);
            end else passed++;
        end
    endtask

    task automatic test_latency();
        int first, width;
        logic [CNT_W-1:0] c0;
        c0 = echo_cnt;
        fire_and_watch("latency5", 12'd5, 20, first, width);
        total++;
        if (first !== 11 || width !== PW || echo_cnt !== c0 + 1'b1) begin
            $display("FAIL latency5 first=%0d width=%0d cnt=%0d want 11/%0d/%0d", first, width, echo_cnt, PW, c0 + 1'b1);
        end else passed++;
        fire_and_watch("latency0", 12'd0, 8, first, width);
        total++;
        if (first !== 1 || width !== PW) begin
            $display("FAIL latency0 first=%0d width=%0d want 1/%0d", first, width, PW);
        end else passed++;
    endtask

    task automatic test_out_of_range();
        logic [CNT_W-1:0] c0;
        int misses, highs;
        c0 = echo_cnt; misses = 0; highs = 0;
        dist_set = OOR; L = 1'b1;
        step();
        L = 1'b0;
        total++;
        if (miss !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL oor_miss miss=%b busy=%b want 1/0", miss, busy);
        end else passed++;
        for (int i = 0; i < 10; i++) begin
            step();
            misses += int'(miss);
            highs  += int'(S);
        end
        total++;
        if (misses !== 0 || highs !== 0 || echo_cnt !== c0) begin
            $display("FAIL oor_after misses=%0d highs=%0d cnt=%0d want 0/0/%0d", misses, highs, echo_cnt, c0);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int k, first, echoes, misses;
        logic [CNT_W-1:0] c0;
        logic s_prev;
        c0 = echo_cnt; first = -1; echoes = 0; misses = 0; s_prev = 1'b0;
        dist_set = 12'd20; L = 1'b1;
        step();
        k = n; L = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            L = (i == 5);
            step();
            if (S && !s_prev) begin echoes++; if (first < 0) first = n - k; end
            s_prev = S;
            misses += int'(miss);
            if (i == 5) begin
                total++;
                if (miss !== 1'b1) $display("FAIL b2b_miss miss=%b want 1", miss);
                else passed++;
            end
        end
        total++;
        if (first !== 41 || echoes !== 1 || misses !== 1 || echo_cnt !== c0 + 1'b1) begin
            $display("FAIL b2b first=%0d echoes=%0d misses=%0d cnt=%0d want 41/1/1/%0d", first, echoes, misses, echo_cnt, c0 + 1'b1);
        end else passed++;
    endtask

    task automatic test_enable_abort();
        int highs, first, width;
        logic [CNT_W-1:0] c0;
        c0 = echo_cnt; highs = 0;
        dist_set = 12'd10; L = 1'b1;
        step();
        L = 1'b0;
        for (int i = 0; i < 3; i++) step();
        en = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || S !== 1'b0) $display("FAIL abort_busy busy=%b S=%b want 0/0", busy, S);
        else passed++;
        for (int i = 0; i < 30; i++) begin
            L = (i == 3);   // rise while disabled: no miss
            step();
            highs += int'(S) + int'(miss);
        end
        total++;
        if (highs !== 0 || echo_cnt !== c0) $display("FAIL abort_quiet S+miss=%0d cnt=%0d want 0/%0d", highs, echo_cnt, c0);
        else passed++;
        L = 1'b0; en = 1'b1;
        step();
        fire_and_watch("after_abort", 12'd10, 26, first, width);
        total++;
        if (first !== 21 || echo_cnt !== c0 + 1'b1) $display("FAIL after_abort first=%0d cnt=%0d want 21/%0d", first, echo_cnt, c0 + 1'b1);
        else passed++;
    endtask

    // Measurement-side view: D = (rise-to-echo cycles - 1) / 2.
    task automatic test_loopback();
        int first, width;
        fire_and_watch("loopback", 12'd100, 206, first, width);
        total++;
        if ((first - 1) / 2 !== 100) $display("FAIL loopback measured=%0d want 100", (first - 1) / 2);
        else passed++;
    endtask

    task automatic test_reset_mid();
        dist_set = 12'd50; L = 1'b1;
        step();
        L = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b0;
        #1;
        total++;
        if (S !== 1'b0 || busy !== 1'b0 || miss !== 1'b0 || echo_cnt !== '0) begin
            $display("FAIL reset_mid S=%b busy=%b miss=%b cnt=%0d want 0", S, busy, miss, echo_cnt);
        end else passed++;
        step();
        reset = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] seen255;
        dist_set = 12'd0;
        seen255 = '0;
        for (int e = 0; e < 256; e++) begin
            L = 1'b1;
            step();
            L = 1'b0;
            for (int i = 0; i < PW + 2; i++) begin
                step();
                if (e == 254) seen255 = echo_cnt;
                total++;
                if (S !== m_s || busy !== m_busy || miss !== m_miss || echo_cnt !== m_cnt) begin
                    $display("FAIL wrap e=%0d S/busy/miss/cnt=%b%b%b/%0d want %b%b%b/%0d", e, S, busy, miss, echo_cnt, m_s, m_busy, m_miss, m_cnt);
                end else passed++;
            end
        end
        total++;
        if (seen255 !== 8'd255 || echo_cnt !== 8'd0) $display("FAIL wrap_end cnt255=%0d cnt=%0d want 255/0", seen255, echo_cnt);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            L        = ($urandom_range(0, 2) == 0);
            en       = ($urandom_range(0, 19) != 0);
            dist_set = ($urandom_range(0, 19) == 0) ? OOR : DW'($urandom_range(0, 12));
            step();
            total++;
            if (S !== m_s || busy !== m_busy || miss !== m_miss || echo_cnt !== m_cnt) begin
                $display("FAIL random n=%0d S/busy/miss/cnt=%b%b%b/%0d want %b%b%b/%0d", n, S, busy, miss, echo_cnt, m_s, m_busy, m_miss, m_cnt);
            end else passed++;
        end
        en = 1'b1; L = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_out_of_range();
        test_back_to_back();
        test_enable_abort();
        test_loopback();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_laser_echo_emulator
`default_nettype wire
